// File: rtl/battle_pkg.sv
// Shared types and keycodes for the team builder and the battle FSM.
package battle_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;

  typedef logic [2:0] species_t;
  typedef species_t [2:0] team_t;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_BROWSE,
    SEL_CONFIRM,
    SEL_LAUNCH,
    SEL_IN_BATTLE
  } sel_state_t;

endpackage

// File: rtl/team_select_if.sv
// Control/status bundle between the game FSM and the team builder.
interface team_select_if #(
  parameter int unsigned NUM_SPECIES = 6
);
  import battle_pkg::*;

  logic                   enable;
  logic [7:0]             keycode;
  logic                   end_battle;
  team_t                  team;
  logic                   start_battle;
  species_t               cursor;
  logic [1:0]             picked_count;
  logic [NUM_SPECIES-1:0] picked_mask;
  logic                   team_locked;

  modport master (
    output enable, keycode, end_battle,
    input  team, start_battle, cursor, picked_count, picked_mask, team_locked
  );

  modport slave (
    input  enable, keycode, end_battle,
    output team, start_battle, cursor, picked_count, picked_mask, team_locked
  );

endinterface

// File: rtl/key_event.sv
// Turns a level-held keycode into a registered one-shot press event.
module key_event (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       key_evt,
  output logic [7:0] key_val
);

  logic [7:0] prev_key;

  // New press = code differs from last cycle and is not "no key".
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_key <= '0;
      key_evt  <= 1'b0;
      key_val  <= '0;
    end else begin
      prev_key <= keycode;
      key_evt  <= (keycode != prev_key) && (keycode != 8'h00);
      key_val  <= keycode;
    end
  end

endmodule

// File: rtl/team_select.sv
// Pre-battle team builder: cursor over a species grid, three distinct picks,
// then a one-cycle start_battle strobe and a frozen team until end_battle.
// Optional feature macro: TEAM_SELECT_UNDO_EN (BKSP removes the last pick).
module team_select
  import battle_pkg::*;
#(
  parameter int unsigned NUM_SPECIES = 6,
  parameter int unsigned GRID_COLS   = 3
) (
  input logic         Clk,
  input logic         Reset,
  team_select_if.slave bus
);

  localparam int unsigned MW    = NUM_SPECIES;
  localparam logic [3:0]  NUM4  = 4'(NUM_SPECIES);
  localparam logic [3:0]  COLS4 = 4'(GRID_COLS);

  sel_state_t    state_q;
  team_t         team_q;
  species_t      cursor_q;
  logic [1:0]    count_q;
  logic [MW-1:0] mask_q;
  logic          start_q;
  logic          locked_q;

  logic          key_evt;
  logic [7:0]    key_val;

  logic [3:0]    cur4;
  logic [3:0]    col4;
  logic          up_ok, dn_ok, lt_ok, rt_ok;
  logic          is_picked;

  key_event u_key_event (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (bus.keycode),
    .key_evt (key_evt),
    .key_val (key_val)
  );

  // Cursor moves are evaluated in 4 bits and range-checked before use.
  always_comb begin
    cur4      = {1'b0, cursor_q};
    col4      = cur4 % COLS4;
    up_ok     = (cur4 >= COLS4);
    dn_ok     = ((cur4 + COLS4) < NUM4);
    lt_ok     = (col4 != 4'd0);
    rt_ok     = (col4 != (COLS4 - 4'd1)) && ((cur4 + 4'd1) < NUM4);
    is_picked = mask_q[cursor_q];
  end

  // Selection FSM with cursor, pick registers and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= SEL_IDLE;
      team_q   <= '0;
      cursor_q <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        SEL_IDLE: begin
          if (bus.enable) begin
            state_q  <= SEL_BROWSE;
            cursor_q <= '0;
          end
        end

        SEL_BROWSE: begin
          if (!bus.enable) begin
            state_q <= SEL_IDLE;
            team_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
          end else if (key_evt) begin
            case (key_val)
              KEY_W:     if (up_ok) cursor_q <= 3'(cur4 - COLS4);
              KEY_S:     if (dn_ok) cursor_q <= 3'(cur4 + COLS4);
              KEY_A:     if (lt_ok) cursor_q <= 3'(cur4 - 4'd1);
              KEY_D:     if (rt_ok) cursor_q <= 3'(cur4 + 4'd1);
              KEY_ENTER: begin
                if (!is_picked) begin
                  team_q[count_q] <= cursor_q;
                  mask_q          <= mask_q | (MW'(1) << cursor_q);
                  count_q         <= (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
                  if (count_q == 2'd2) state_q <= SEL_CONFIRM;
                end
              end
`ifdef TEAM_SELECT_UNDO_EN
              KEY_BKSP: begin
                if (count_q != 2'd0) begin
                  mask_q[team_q[count_q - 2'd1]] <= 1'b0;
                  team_q[count_q - 2'd1]         <= '0;
                  count_q                        <= count_q - 2'd1;
                end
              end
`endif
              default: ;
            endcase
          end
        end

        SEL_CONFIRM: begin
          if (!bus.enable) begin
            state_q <= SEL_IDLE;
            team_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
          end else if (key_evt && (key_val == KEY_ENTER)) begin
            state_q  <= SEL_LAUNCH;
            start_q  <= 1'b1;
            locked_q <= 1'b1;
          end
`ifdef TEAM_SELECT_UNDO_EN
          else if (key_evt && (key_val == KEY_BKSP) && (count_q != 2'd0)) begin
            mask_q[team_q[count_q - 2'd1]] <= 1'b0;
            team_q[count_q - 2'd1]         <= '0;
            count_q                        <= count_q - 2'd1;
            state_q                        <= SEL_BROWSE;
          end
`endif
        end

        SEL_LAUNCH: begin
          state_q <= SEL_IN_BATTLE;
        end

        SEL_IN_BATTLE: begin
          if (bus.end_battle) begin
            state_q  <= SEL_IDLE;
            team_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
          end
        end

        default: state_q <= SEL_IDLE;
      endcase
    end
  end

  assign bus.team         = team_q;
  assign bus.start_battle = start_q;
  assign bus.cursor       = cursor_q;
  assign bus.picked_count = count_q;
  assign bus.picked_mask  = mask_q;
  assign bus.team_locked  = locked_q;

endmodule

// File: tb/tb_team_select.sv
// Directed bench for team_select with an expected-output scoreboard queue.
module tb_team_select;
  import battle_pkg::*;

  logic Clk;
  logic Reset;

  team_select_if #(.NUM_SPECIES(6)) bus ();

  team_select #(.NUM_SPECIES(6), .GRID_COLS(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    logic       chk_cur;
    logic [2:0] cur;
    logic [1:0] cnt;
    logic [5:0] mask;
    logic [8:0] team;
    logic       locked;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  // Count start_battle pulses, sampled mid-cycle.
  always @(negedge Clk) if (bus.start_battle === 1'b1) pulses++;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic chk_cur, input logic [2:0] cur,
                      input logic [1:0] cnt, input logic [5:0] mask,
                      input logic [8:0] team, input logic locked);
    exp_t e;
    e.tag = tag; e.chk_cur = chk_cur; e.cur = cur; e.cnt = cnt;
    e.mask = mask; e.team = team; e.locked = locked;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      if (e.chk_cur) chk({e.tag, ".cursor"}, 32'(bus.cursor), 32'(e.cur));
      chk({e.tag, ".count"},  32'(bus.picked_count), 32'(e.cnt));
      chk({e.tag, ".mask"},   32'(bus.picked_mask),  32'(e.mask));
      chk({e.tag, ".team"},   32'(bus.team),         32'(e.team));
      chk({e.tag, ".locked"}, 32'(bus.team_locked),  32'(e.locked));
    end
  endtask

  // One press: event registers on the first edge, acts on the second, then release.
  task automatic press(input logic [7:0] k);
    bus.keycode = k;
    tick();
    tick();
    bus.keycode = 8'h00;
    tick();
  endtask

  task automatic step(input string tag, input logic [7:0] k, input logic chk_cur,
                      input logic [2:0] cur, input logic [1:0] cnt, input logic [5:0] mask,
                      input logic [8:0] team, input logic locked);
    push(tag, chk_cur, cur, cnt, mask, team, locked);
    press(k);
    sb_check();
  endtask

  // Confirm -> Launch -> In_Battle with the strobe checked cycle by cycle.
  task automatic launch(input string tag);
    bus.keycode = KEY_ENTER;
    tick();
    tick();
    chk({tag, ".start_hi"},  32'(bus.start_battle), 32'd1);
    chk({tag, ".locked_hi"}, 32'(bus.team_locked),  32'd1);
    tick();
    chk({tag, ".start_lo"},  32'(bus.start_battle), 32'd0);
    bus.keycode = 8'h00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    bus.enable = 1'b0;
    bus.keycode = 8'h00;
    bus.end_battle = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    chk("reset.start", 32'(bus.start_battle), 32'd0);
    push("reset", 1'b1, 3'd0, 2'd0, 6'b000000, 9'h000, 1'b0);
    sb_check();

    // Held key gives one step; right edge of row holds.
    bus.enable = 1'b1;
    tick();
    bus.keycode = KEY_D;
    repeat (5) tick();
    bus.keycode = 8'h00;
    chk("hold_d.cursor", 32'(bus.cursor), 32'd1);
    tick();
    step("d2",      KEY_D, 1'b1, 3'd2, 2'd0, 6'b000000, 9'h000, 1'b0);
    step("d_edge",  KEY_D, 1'b1, 3'd2, 2'd0, 6'b000000, 9'h000, 1'b0);
    step("a1",      KEY_A, 1'b1, 3'd1, 2'd0, 6'b000000, 9'h000, 1'b0);
    step("a0",      KEY_A, 1'b1, 3'd0, 2'd0, 6'b000000, 9'h000, 1'b0);
    step("a_edge",  KEY_A, 1'b1, 3'd0, 2'd0, 6'b000000, 9'h000, 1'b0);

    // Duplicate pick is ignored.
    step("pick0",   KEY_ENTER, 1'b1, 3'd0, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("dup0",    KEY_ENTER, 1'b1, 3'd0, 2'd1, 6'b000001, 9'h000, 1'b0);

    // Picks 4 and 2 with vertical boundary holds.
    step("s3",      KEY_S, 1'b1, 3'd3, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("d4",      KEY_D, 1'b1, 3'd4, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("s_edge",  KEY_S, 1'b1, 3'd4, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("pick4",   KEY_ENTER, 1'b1, 3'd4, 2'd2, 6'b010001, 9'h020, 1'b0);
    step("w1",      KEY_W, 1'b1, 3'd1, 2'd2, 6'b010001, 9'h020, 1'b0);
    step("w_edge",  KEY_W, 1'b1, 3'd1, 2'd2, 6'b010001, 9'h020, 1'b0);
    step("d2b",     KEY_D, 1'b1, 3'd2, 2'd2, 6'b010001, 9'h020, 1'b0);
    step("pick2",   KEY_ENTER, 1'b1, 3'd2, 2'd3, 6'b010101, 9'h0A0, 1'b0);
    step("confirm_a", KEY_A, 1'b1, 3'd2, 2'd3, 6'b010101, 9'h0A0, 1'b0);

    // Launch, frozen team, end_battle beats a simultaneous key.
    launch("launch1");
    chk("launch1.pulses", 32'(pulses), 32'd1);
    step("battle_w", KEY_W, 1'b1, 3'd2, 2'd3, 6'b010101, 9'h0A0, 1'b1);
    bus.enable = 1'b0;
    tick();
    tick();
    push("battle_noen", 1'b1, 3'd2, 2'd3, 6'b010101, 9'h0A0, 1'b1);
    sb_check();
    bus.enable = 1'b1;
    bus.keycode = KEY_D;
    tick();
    bus.end_battle = 1'b1;
    tick();
    bus.end_battle = 1'b0;
    bus.keycode = 8'h00;
    push("end_battle", 1'b0, 3'd0, 2'd0, 6'b000000, 9'h000, 1'b0);
    sb_check();
    tick();
    chk("rebrowse.cursor", 32'(bus.cursor), 32'd0);

    // Disable after two picks clears them.
    step("p5a",  KEY_ENTER, 1'b1, 3'd0, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("p5d",  KEY_D,     1'b1, 3'd1, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("p5b",  KEY_ENTER, 1'b1, 3'd1, 2'd2, 6'b000011, 9'h008, 1'b0);
    bus.enable = 1'b0;
    tick();
    push("disable", 1'b1, 3'd1, 2'd0, 6'b000000, 9'h000, 1'b0);
    sb_check();
    bus.enable = 1'b1;
    tick();
    chk("reenable.cursor", 32'(bus.cursor), 32'd0);

    // Reset while in battle.
    step("r0",  KEY_ENTER, 1'b1, 3'd0, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("rd",  KEY_D,     1'b1, 3'd1, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("r1",  KEY_ENTER, 1'b1, 3'd1, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("rs",  KEY_S,     1'b1, 3'd4, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("r4",  KEY_ENTER, 1'b1, 3'd4, 2'd3, 6'b010011, 9'h108, 1'b0);
    launch("launch2");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midreset.start", 32'(bus.start_battle), 32'd0);
    push("midreset", 1'b1, 3'd0, 2'd0, 6'b000000, 9'h000, 1'b0);
    sb_check();
    repeat (3) tick();
    chk("midreset.pulses", 32'(pulses), 32'd2);

    // BKSP in Confirm.
    step("u0",  KEY_ENTER, 1'b1, 3'd0, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("ud",  KEY_D,     1'b1, 3'd1, 2'd1, 6'b000001, 9'h000, 1'b0);
    step("u1",  KEY_ENTER, 1'b1, 3'd1, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("ua",  KEY_A,     1'b1, 3'd0, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("us",  KEY_S,     1'b1, 3'd3, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("u3",  KEY_ENTER, 1'b1, 3'd3, 2'd3, 6'b001011, 9'h0C8, 1'b0);
`ifdef TEAM_SELECT_UNDO_EN
    step("bksp",      KEY_BKSP, 1'b1, 3'd3, 2'd2, 6'b000011, 9'h008, 1'b0);
    step("bksp_move", KEY_D,    1'b1, 3'd4, 2'd2, 6'b000011, 9'h008, 1'b0);
    chk("final.pulses", 32'(pulses), 32'd2);
`else
    step("bksp",      KEY_BKSP, 1'b1, 3'd3, 2'd3, 6'b001011, 9'h0C8, 1'b0);
    launch("launch3");
    chk("final.pulses", 32'(pulses), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
